// File: rtl/ysyx_25060173_mem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between IFU and LSU.
// One outstanding transaction; the response is held until the owner accepts it.
module ysyx_25060173_mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ifu_req_valid,
  output logic            ifu_req_ready,
  input  logic [AW-1:0]   ifu_addr,
  output logic            ifu_rsp_valid,
  input  logic            ifu_rsp_ready,
  output logic [DW-1:0]   ifu_rdata,
  input  logic            lsu_req_valid,
  output logic            lsu_req_ready,
  input  logic [AW-1:0]   lsu_addr,
  input  logic            lsu_wen,
  input  logic [DW-1:0]   lsu_wdata,
  input  logic [DW/8-1:0] lsu_wmask,
  output logic            lsu_rsp_valid,
  input  logic            lsu_rsp_ready,
  output logic [DW-1:0]   lsu_rdata,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [AW-1:0]   mem_addr,
  output logic            mem_wen,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wmask,
  input  logic            mem_rsp_valid,
  input  logic [DW-1:0]   mem_rdata
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

  state_t          r_state;
  logic            r_owner_lsu;
  logic            r_last_lsu;
  logic [AW-1:0]   r_addr;
  logic            r_wen;
  logic [DW-1:0]   r_wdata;
  logic [DW/8-1:0] r_wmask;
  logic [DW-1:0]   r_rdata;

  logic w_idle;
  logic w_gnt_ifu;
  logic w_gnt_lsu;
  logic w_owner_rsp_ready;

  // Ties go to whichever requester did not win last; ready is masked while reset is held.
  assign w_idle    = (r_state == ST_IDLE) && !reset;
  assign w_gnt_lsu = lsu_req_valid && (!ifu_req_valid || !r_last_lsu);
  assign w_gnt_ifu = ifu_req_valid && (!lsu_req_valid ||  r_last_lsu);
  assign w_owner_rsp_ready = r_owner_lsu ? lsu_rsp_ready : ifu_rsp_ready;

  assign ifu_req_ready = w_idle && w_gnt_ifu;
  assign lsu_req_ready = w_idle && w_gnt_lsu;

  assign mem_req_valid = (r_state == ST_ISSUE);
  assign mem_addr      = r_addr;
  assign mem_wen       = r_wen;
  assign mem_wdata     = r_wdata;
  assign mem_wmask     = r_wmask;

  assign ifu_rsp_valid = (r_state == ST_RESP) && !r_owner_lsu;
  assign lsu_rsp_valid = (r_state == ST_RESP) &&  r_owner_lsu;
  assign ifu_rdata     = r_rdata;
  assign lsu_rdata     = r_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_owner_lsu <= 1'b0;
      r_last_lsu  <= 1'b0;
      r_addr      <= '0;
      r_wen       <= 1'b0;
      r_wdata     <= '0;
      r_wmask     <= '0;
      r_rdata     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_gnt_lsu) begin
            r_addr      <= lsu_addr;
            r_wen       <= lsu_wen;
            r_wdata     <= lsu_wdata;
            r_wmask     <= lsu_wmask;
            r_owner_lsu <= 1'b1;
            r_last_lsu  <= 1'b1;
            r_state     <= ST_ISSUE;
          end else if (w_gnt_ifu) begin
            r_addr      <= ifu_addr;
            r_wen       <= 1'b0;
            r_wdata     <= '0;
            r_wmask     <= '0;
            r_owner_lsu <= 1'b0;
            r_last_lsu  <= 1'b0;
            r_state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: if (mem_req_ready) r_state <= ST_WAIT;
        ST_WAIT: begin
          if (mem_rsp_valid) begin
            r_rdata <= mem_rdata;
            r_state <= ST_RESP;
          end
        end
        ST_RESP: if (w_owner_rsp_ready) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25060173_mem_arbiter.sv
// Self-checking bench for the IFU/LSU memory arbiter: directed sequences plus
// randomized traffic checked against a transaction-level reference model.
module tb_ysyx_25060173_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid, lsu_rsp_ready;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  int checks = 0;
  int failures = 0;

  logic [31:0] e_addr, e_wd;
  logic        e_wen;
  logic [3:0]  e_wm;

  ysyx_25060173_mem_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    ifu_req_valid = 0; ifu_addr = '0; ifu_rsp_ready = 0;
    lsu_req_valid = 0; lsu_addr = '0; lsu_wen = 0; lsu_wdata = '0; lsu_wmask = '0;
    lsu_rsp_ready = 0; mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic req_ifu(input logic [31:0] a);
    @(negedge clk);
    ifu_req_valid = 1; ifu_addr = a;
    e_addr = a; e_wen = 0; e_wd = '0; e_wm = '0;
    #1 chk("ifu_accept", {ifu_req_ready, lsu_req_ready}, 2'b10);
    @(posedge clk);
    #1 ifu_req_valid = 0;
  endtask

  task automatic req_lsu(input logic [31:0] a, input logic w, input logic [31:0] d,
                         input logic [3:0] m);
    @(negedge clk);
    lsu_req_valid = 1; lsu_addr = a; lsu_wen = w; lsu_wdata = d; lsu_wmask = m;
    e_addr = a; e_wen = w; e_wd = d; e_wm = m;
    #1 chk("lsu_accept", {ifu_req_ready, lsu_req_ready}, 2'b01);
    @(posedge clk);
    #1 lsu_req_valid = 0;
  endtask

  // Called in the cycle after acceptance; returns in the cycle after the response handshake.
  task automatic complete(input bit own_lsu, input logic [31:0] data,
                          input int req_stall, input int rsp_stall);
    for (int i = 0; i <= req_stall; i++) begin
      @(negedge clk);
      mem_req_ready = (i == req_stall);
      #1;
      chk("issue_valid", mem_req_valid, 1'b1);
      chk("issue_fields", {mem_addr, mem_wen, mem_wdata, mem_wmask}, {e_addr, e_wen, e_wd, e_wm});
      chk("issue_noready", {ifu_req_ready, lsu_req_ready}, 2'b00);
    end
    @(negedge clk);
    mem_req_ready = 0; mem_rsp_valid = 1; mem_rdata = data;
    #1 chk("wait_state", {mem_req_valid, ifu_rsp_valid, lsu_rsp_valid}, 3'b000);
    for (int i = 0; i <= rsp_stall; i++) begin
      @(negedge clk);
      mem_rsp_valid = 0; mem_rdata = $urandom;
      if (own_lsu) lsu_rsp_ready = (i == rsp_stall);
      else         ifu_rsp_ready = (i == rsp_stall);
      #1;
      chk("resp_valid", {ifu_rsp_valid, lsu_rsp_valid}, own_lsu ? 2'b01 : 2'b10);
      chk("resp_data", own_lsu ? lsu_rdata : ifu_rdata, data);
      chk("resp_noready", {ifu_req_ready, lsu_req_ready}, 2'b00);
    end
    @(negedge clk);
    ifu_rsp_ready = 0; lsu_rsp_ready = 0;
    #1 chk("back_idle", {mem_req_valid, ifu_rsp_valid, lsu_rsp_valid}, 3'b000);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (m[b]) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction

  typedef struct {
    logic iv, lv, e_ir, e_lr;
  } vec_t;

  initial begin
    vec_t tbl[4];
    logic [31:0] mem_a[8];
    logic [31:0] ref_a[8];
    bit ip, lp, last_lsu, o_out, o_iss, o_got, o_own_lsu, mb, e_ir, e_lr;
    logic [31:0] ia, la, lwd, o_addr, o_wd, o_exp, mdata;
    logic        lwe, o_wen;
    logic [3:0]  lwm, o_wm;
    logic [2:0]  idx;
    int iage, lage, md, ntx;

    tbl[0] = '{iv: 0, lv: 0, e_ir: 0, e_lr: 0};
    tbl[1] = '{iv: 1, lv: 0, e_ir: 1, e_lr: 0};
    tbl[2] = '{iv: 0, lv: 1, e_ir: 0, e_lr: 1};
    tbl[3] = '{iv: 1, lv: 1, e_ir: 0, e_lr: 1};

    reset = 1'b1;
    idle_inputs();
    #1;
    chk("rst_ctrl", {ifu_req_ready, lsu_req_ready, ifu_rsp_valid, lsu_rsp_valid, mem_req_valid, mem_wen}, 6'b0);
    chk("rst_data", {mem_addr, mem_wdata, mem_wmask, ifu_rdata, lsu_rdata}, '0);
    do_reset();

    // Grant decode from IDLE with last_grant = IFU; valids drop before the edge.
    for (int unsigned k = 0; k < 4; k++) begin
      @(negedge clk);
      ifu_req_valid = tbl[k].iv; lsu_req_valid = tbl[k].lv;
      #1 chk($sformatf("tbl_%0d", k), {ifu_req_ready, lsu_req_ready}, {tbl[k].e_ir, tbl[k].e_lr});
      #1 ifu_req_valid = 0; lsu_req_valid = 0;
    end

    // Single IFU fetch at minimum latency.
    req_ifu(32'h8000_0000);
    complete(1'b0, 32'h0010_0093, 0, 0);
    chk("fetch_lsu_rdata", lsu_rdata, 32'h0010_0093);

    // Tie arbitration from reset: LSU, IFU, LSU.
    do_reset();
    @(negedge clk);
    ifu_req_valid = 1; ifu_addr = 32'h8000_0100;
    lsu_req_valid = 1; lsu_addr = 32'h8000_0200; lsu_wen = 0; lsu_wdata = '0; lsu_wmask = '0;
    #1 chk("tie1", {ifu_req_ready, lsu_req_ready}, 2'b01);
    e_addr = 32'h8000_0200; e_wen = 0; e_wd = '0; e_wm = '0;
    @(posedge clk);
    complete(1'b1, 32'h1111_1111, 0, 0);
    chk("tie2", {ifu_req_ready, lsu_req_ready}, 2'b10);
    e_addr = 32'h8000_0100;
    @(posedge clk);
    complete(1'b0, 32'h2222_2222, 0, 0);
    chk("tie3", {ifu_req_ready, lsu_req_ready}, 2'b01);
    e_addr = 32'h8000_0200;
    @(posedge clk);
    #1 ifu_req_valid = 0; lsu_req_valid = 0;
    complete(1'b1, 32'h3333_3333, 0, 0);

    // Store with request stall and response backpressure while IFU waits.
    req_lsu(32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'b0011);
    ifu_req_valid = 1; ifu_addr = 32'h8000_0004;
    complete(1'b1, 32'hCAFE_F00D, 3, 5);
    chk("store_then_ifu", {ifu_req_ready, lsu_req_ready}, 2'b10);
    #1 ifu_req_valid = 0;

    // Spurious response pulses in IDLE and ISSUE.
    @(negedge clk);
    mem_rsp_valid = 1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    mem_rsp_valid = 0;
    #1 chk("spur_idle", {ifu_rdata, mem_req_valid, ifu_rsp_valid, lsu_rsp_valid}, {32'hCAFE_F00D, 3'b000});
    req_ifu(32'h8000_0008);
    @(negedge clk);
    mem_rsp_valid = 1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    mem_rsp_valid = 0;
    #1 chk("spur_issue", {ifu_rdata, mem_req_valid, ifu_rsp_valid}, {32'hCAFE_F00D, 2'b10});
    complete(1'b0, 32'hA5A5_0F0F, 0, 0);

    // Asynchronous reset while waiting for memory.
    req_ifu(32'h8000_0010);
    @(negedge clk);
    mem_req_ready = 1;
    @(negedge clk);
    mem_req_ready = 0;
    #1 chk("pre_rst_wait", {mem_req_valid, ifu_rsp_valid}, 2'b00);
    #1 ifu_req_valid = 1; lsu_req_valid = 1; reset = 1;
    #1;
    chk("arst_ctrl", {ifu_req_ready, lsu_req_ready, ifu_rsp_valid, lsu_rsp_valid, mem_req_valid, mem_wen}, 6'b0);
    chk("arst_data", {mem_addr, mem_wdata, mem_wmask, ifu_rdata, lsu_rdata}, '0);
    ifu_req_valid = 0; lsu_req_valid = 0;
    @(negedge clk);
    reset = 0;
    req_ifu(32'h8000_0020);
    complete(1'b0, 32'h0BAD_F00D, 1, 1);

    // Randomized traffic against a transaction-level model.
    do_reset();
    for (int unsigned k = 0; k < 8; k++) begin
      mem_a[k] = $urandom;
      ref_a[k] = mem_a[k];
    end
    ip = 0; lp = 0; last_lsu = 0; o_out = 0; o_iss = 0; o_got = 0; o_own_lsu = 0; mb = 0;
    ia = '0; la = '0; lwd = '0; lwe = 0; lwm = '0;
    o_addr = '0; o_wd = '0; o_wen = 0; o_wm = '0; o_exp = '0; mdata = '0;
    iage = 0; lage = 0; md = 0; ntx = 0;
    for (int unsigned cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (!ip && $urandom_range(0, 1) == 1) begin
        ip = 1; iage = 0;
        ia = 32'h8000_0000 + 32'($urandom_range(0, 7) * 4);
      end
      if (!lp && $urandom_range(0, 1) == 1) begin
        lp = 1; lage = 0;
        la = 32'h8000_0000 + 32'($urandom_range(0, 7) * 4);
        lwe = 1'($urandom_range(0, 1)); lwd = $urandom; lwm = 4'($urandom_range(0, 15));
      end
      ifu_req_valid = ip; ifu_addr = ia;
      lsu_req_valid = lp; lsu_addr = la; lsu_wen = lwe; lsu_wdata = lwd; lsu_wmask = lwm;
      ifu_rsp_ready = 1'($urandom_range(0, 1));
      lsu_rsp_ready = 1'($urandom_range(0, 1));
      mem_req_ready = 1'($urandom_range(0, 1));
      mem_rsp_valid = mb && (md == 0);
      mem_rdata = mem_rsp_valid ? mdata : $urandom;
      #1;
      e_ir = !o_out && ip && (!lp || last_lsu);
      e_lr = !o_out && lp && (!ip || !last_lsu);
      chk("rnd_ready", {ifu_req_ready, lsu_req_ready}, {e_ir, e_lr});
      chk("rnd_mreq", mem_req_valid, o_out && !o_iss);
      if (o_out && !o_iss)
        chk("rnd_mfields", {mem_addr, mem_wen, mem_wdata, mem_wmask}, {o_addr, o_wen, o_wd, o_wm});
      chk("rnd_rspv", {ifu_rsp_valid, lsu_rsp_valid},
          {o_out && o_got && !o_own_lsu, o_out && o_got && o_own_lsu});
      if (o_out && o_got) chk("rnd_rdata", o_own_lsu ? lsu_rdata : ifu_rdata, o_exp);

      if (o_out && o_got && (o_own_lsu ? lsu_rsp_ready : ifu_rsp_ready)) begin
        o_out = 0; ntx++;
      end
      if (mem_rsp_valid) begin
        mb = 0; o_got = 1;
      end else if (mb && md > 0) md--;
      if (o_out && !o_iss && mem_req_ready) begin
        o_iss = 1; mb = 1; md = int'($urandom_range(0, 2));
        idx = mem_addr[4:2];
        mdata = mem_a[idx];
        if (mem_wen) mem_a[idx] = merge(mem_a[idx], mem_wdata, mem_wmask);
      end
      if (e_ir) begin
        o_out = 1; o_iss = 0; o_got = 0; o_own_lsu = 0; last_lsu = 0; ip = 0;
        o_addr = ia; o_wen = 0; o_wd = '0; o_wm = '0;
        idx = ia[4:2];
        o_exp = ref_a[idx];
      end else if (e_lr) begin
        o_out = 1; o_iss = 0; o_got = 0; o_own_lsu = 1; last_lsu = 1; lp = 0;
        o_addr = la; o_wen = lwe; o_wd = lwd; o_wm = lwm;
        idx = la[4:2];
        o_exp = ref_a[idx];
        if (lwe) ref_a[idx] = merge(ref_a[idx], lwd, lwm);
      end
      if (ip) iage++;
      if (lp) lage++;
      if (iage > 100 || lage > 100) begin
        checks++; failures++;
        $display("FAIL rnd_starve ifu_age=%0d lsu_age=%0d required<=100", iage, lage);
        iage = 0; lage = 0;
      end
    end
    chk("rnd_progress", ntx > 100, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
